bsg_manycore_link_rr_arb: RTL and testbench

- Round-robin arbiter that shares one ready_and link (core side of an SDR link pearl) among num_req_p requesters.
- Grants are packet-atomic. The header flit carries a body-flit count, and the grant is locked until the last body flit transfers.
- Sits between manycore-side link_sif producers and a single pod-link channel, so several subpod streams can share one off-chip SDR link.

---
 rtl/bsg_manycore_link_rr_arb.sv | 164 ++++++++++++++++
 tb/tb_bsg_manycore_link_rr_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_link_rr_arb.sv
// Packet-atomic round-robin arbiter sharing one ready_and link among num_req_p requesters.
// The header's low len_width_p bits give the body-flit count; the grant locks until the last body flit.
module bsg_manycore_link_rr_arb #(
  parameter int num_req_p    = 4,
  parameter int data_width_p = 32,
  parameter int len_width_p  = 4,
  localparam int id_w        = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_req_p*data_width_p-1:0] data_i,
  input  logic [num_req_p-1:0]              v_i,
  output logic [num_req_p-1:0]              ready_and_o,
  output logic [data_width_p-1:0]           data_o,
  output logic                              v_o,
  input  logic                              ready_and_i,
  output logic [id_w-1:0]                   grant_id_o,
  output logic                              locked_o
);

  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} st_e;

  st_e                    st_r, st_n;
  logic [id_w-1:0]        rr_ptr_r, ptr_n;
  logic [id_w-1:0]        gnt_r, gnt_n;
  logic                   hold_r, hold_n;
  logic [len_width_p-1:0] cnt_r, cnt_n;

  logic [id_w-1:0]         scan_sel, sel, idx;
  logic [data_width_p-1:0] data_sel;
  logic [len_width_p-1:0]  len;
  logic                    xfer;
  int                      t;

  // Wrap by explicit compare so non-power-of-two requester counts work.
  function automatic logic [id_w-1:0] next_id(input logic [id_w-1:0] id);
    if (id == id_w'(num_req_p - 1)) next_id = '0;
    else next_id = id + id_w'(1);
  endfunction

  // Lowest rotated offset from rr_ptr_r with a valid request wins; rr_ptr_r if none.
  always_comb begin
    scan_sel = rr_ptr_r;
    t        = 0;
    idx      = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      t        = int'(rr_ptr_r) + k;
      t        = (t >= num_req_p) ? t - num_req_p : t;
      idx      = id_w'(t);
      scan_sel = v_i[idx] ? idx : scan_sel;
    end
  end

  // Zero-latency datapath steered by the current selection.
  always_comb begin
    if (st_r == BODY || hold_r) sel = gnt_r;
    else sel = scan_sel;
    data_sel    = data_i[int'(sel)*data_width_p +: data_width_p];
    data_o      = data_sel;
    len         = data_sel[len_width_p-1:0];
    v_o         = !reset_i && v_i[sel];
    ready_and_o = '0;
    if (!reset_i) ready_and_o[sel] = ready_and_i;
    else ready_and_o = '0;
    grant_id_o  = reset_i ? '0 : sel;
    locked_o    = !reset_i && (st_r == BODY);
    xfer        = v_o && ready_and_i;
  end

  // Next-state logic for arbitration, offer hold and body counting.
  always_comb begin
    st_n   = st_r;
    ptr_n  = rr_ptr_r;
    gnt_n  = gnt_r;
    hold_n = hold_r;
    cnt_n  = cnt_r;
    case (st_r)
      IDLE: begin
        if (xfer) begin
          hold_n = 1'b0;
          if (len == '0) begin
            ptr_n = next_id(sel);
          end else begin
            gnt_n = sel;
            cnt_n = len;
            st_n  = BODY;
          end
        end else if (v_o) begin
          gnt_n  = sel;
          hold_n = 1'b1;
        end else begin
          hold_n = hold_r;
        end
      end
      BODY: begin
        if (xfer) begin
          cnt_n = cnt_r - len_width_p'(1);
          if (cnt_r == len_width_p'(1)) begin
            st_n  = IDLE;
            ptr_n = next_id(gnt_r);
          end else begin
            st_n = BODY;
          end
        end else begin
          cnt_n = cnt_r;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      st_r     <= IDLE;
      rr_ptr_r <= '0;
      gnt_r    <= '0;
      hold_r   <= 1'b0;
      cnt_r    <= '0;
    end else begin
      st_r     <= st_n;
      rr_ptr_r <= ptr_n;
      gnt_r    <= gnt_n;
      hold_r   <= hold_n;
      cnt_r    <= cnt_n;
    end
  end

  bsg_manycore_link_rr_arb_chk #(.num_req_p(num_req_p), .id_w(id_w)) chk (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (v_i),
    .ready_and_o (ready_and_o),
    .in_body     (st_r == BODY),
    .gnt         (gnt_r)
  );

endmodule

// Simulation checks: at most one ready, and no foreign transfer while a packet is locked.
module bsg_manycore_link_rr_arb_chk #(
  parameter int num_req_p = 4,
  parameter int id_w      = 2
) (
  input logic                 clk_i,
  input logic                 reset_i,
  input logic [num_req_p-1:0] v_i,
  input logic [num_req_p-1:0] ready_and_o,
  input logic                 in_body,
  input logic [id_w-1:0]      gnt
);

  logic [num_req_p-1:0] others;
  assign others = v_i & ready_and_o & ~(num_req_p'(1) << gnt);

  // Sample on the clock edge outside reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert ($onehot0(ready_and_o));
      assert (!in_body || others == '0);
    end
  end

endmodule

// File: tb/tb_bsg_manycore_link_rr_arb.sv
// Randomized and directed bench for bsg_manycore_link_rr_arb against a packet-level reference model.
module tb_bsg_manycore_link_rr_arb;
  localparam int N = 4, W = 32, L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]   v = '0;
  logic           rdy = 1'b0;
  logic [N-1:0]   ready_and_o;
  logic [W-1:0]   data_o;
  logic           v_o, locked_o;
  logic [1:0]     grant_id_o;

  bsg_manycore_link_rr_arb #(.num_req_p(N), .data_width_p(W), .len_width_p(L)) dut (
    .clk_i(clk), .reset_i(rst), .data_i(data), .v_i(v), .ready_and_o(ready_and_o),
    .data_o(data_o), .v_o(v_o), .ready_and_i(rdy), .grant_id_o(grant_id_o), .locked_o(locked_o));

  logic           rst3 = 1'b1;
  logic [3*W-1:0] data3 = '0;
  logic [2:0]     v3 = '0;
  logic           rdy3 = 1'b0;
  logic [2:0]     ready3;
  logic [W-1:0]   data3_o;
  logic           v3_o, locked3_o;
  logic [1:0]     grant3_o;

  bsg_manycore_link_rr_arb #(.num_req_p(3), .data_width_p(W), .len_width_p(L)) dut3 (
    .clk_i(clk), .reset_i(rst3), .data_i(data3), .v_i(v3), .ready_and_o(ready3),
    .data_o(data3_o), .v_o(v3_o), .ready_and_i(rdy3), .grant_id_o(grant3_o), .locked_o(locked3_o));

  int checks = 0, errors = 0;
  // Model: owner<0 means free arbitration; owner>=0 with left==0 is a held offer; left>0 is a locked packet.
  int m_owner = -1, m_left = 0, m_ptr = 0;
  int e_sel;
  logic e_v, e_lock;
  logic [N-1:0] e_rdy;
  logic [1:0] e_gnt;
  logic [W-1:0] e_data;

  task automatic model_eval();
    int s;
    bit found;
    s = m_ptr;
    found = 1'b0;
    if (m_owner >= 0) s = m_owner;
    else
      for (int k = 0; k < N; k++)
        if (!found && v[(m_ptr + k) % N]) begin s = (m_ptr + k) % N; found = 1'b1; end
    e_sel  = s;
    e_v    = !rst && v[s];
    e_rdy  = '0;
    if (!rst) e_rdy[s] = rdy;
    e_gnt  = rst ? 2'd0 : 2'(s);
    e_lock = !rst && (m_left > 0);
    e_data = data[s*W +: W];
  endtask

  task automatic model_step();
    int len;
    if (rst) begin
      m_owner = -1; m_left = 0; m_ptr = 0;
    end else if (e_v && rdy) begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
      end else begin
        len = int'(e_data[L-1:0]);
        if (len == 0) begin m_owner = -1; m_ptr = (e_sel + 1) % N; end
        else begin m_owner = e_sel; m_left = len; end
      end
    end else if (e_v && m_owner < 0) begin
      m_owner = e_sel;
    end
  endtask

  function automatic logic [39:0] obs();
    return {v_o, locked_o, ready_and_o, (e_v | rst) ? grant_id_o : 2'd0, e_v ? data_o : 32'd0};
  endfunction

  function automatic logic [39:0] expv();
    return {e_v, e_lock, e_rdy, (e_v | rst) ? e_gnt : 2'd0, e_v ? e_data : 32'd0};
  endfunction

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic put(input int i, input int len);
    data[i*W +: W] = {28'($urandom), 4'(len)};
  endtask

  task automatic do_reset();
    rst = 1'b1; v = '0; rdy = 1'b1;
    settle(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; v = 4'($urandom); rdy = 1'b1;
    for (int i = 0; i < N; i++) put(i, 0);
    settle();
    checks++;
    if (v_o !== 1'b0 || ready_and_o !== 4'b0 || grant_id_o !== 2'b0 || locked_o !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got v=%b r=%b g=%0d l=%b want 0", v_o, ready_and_o, grant_id_o, locked_o);
    end
    tick();
    rst = 1'b0; v = '0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) v = 4'b0100;
      if (c == 2) begin rst = 1'b1; v = '0; end
      settle();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL reset_idle c=%0d got=%h want=%h", c, obs(), expv()); end
      tick();
    end
    rst = 1'b0; v = 4'b1111;
    settle();
    checks++;
    if (grant_id_o !== 2'd0 || v_o !== 1'b1) begin
      errors++; $display("FAIL reset_ptr got g=%0d v=%b want g=0 v=1", grant_id_o, v_o);
    end
    tick();
  endtask

  task automatic test_rr_order();
    do_reset();
    v = 4'b1111; rdy = 1'b1;
    for (int c = 0; c < 9; c++) begin
      for (int i = 0; i < N; i++) put(i, 0);
      settle();
      checks++;
      if (obs() !== expv() || grant_id_o !== 2'(c % N)) begin
        errors++; $display("FAIL rr_order c=%0d got=%h g=%0d want=%h g=%0d", c, obs(), grant_id_o, expv(), c % N);
      end
      tick();
    end
  endtask

  task automatic test_packet_lock();
    do_reset();
    v = 4'b0001; rdy = 1'b1; put(0, 0);
    settle(); tick();
    v = 4'b0111;
    for (int c = 0; c < 6; c++) begin
      put(0, 0); put(2, 0);
      if (c == 0) put(1, 3); else data[W +: W] = $urandom;
      settle();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL packet_lock c=%0d got=%h want=%h", c, obs(), expv()); end
      tick();
    end
  endtask

  task automatic test_hold();
    logic [1:0] vs [7];
    do_reset();
    put(0, 0); put(2, 0); put(3, 0);
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin v = 4'b0100; rdy = 1'b0; end
        1, 2: begin v = 4'b0101; rdy = 1'b0; end
        3: begin v = 4'b0001; rdy = 1'b0; end
        4: begin v = 4'b0101; rdy = 1'b1; end
        5: begin v = 4'b1001; rdy = 1'b1; end
        default: begin v = 4'b0001; rdy = 1'b1; end
      endcase
      settle();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL hold c=%0d got=%h want=%h", c, obs(), expv()); end
      tick();
    end
  endtask

  task automatic test_bubbles_reset();
    logic [3:0] pat;
    do_reset();
    pat = 4'b1001;
    rdy = 1'b1; v = 4'b0001; put(0, 2);
    settle(); tick();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin v = {3'b000, pat[c]}; data[W-1:0] = $urandom; end
      else begin v = 4'b0011; put(0, 0); put(1, 0); end
      settle();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL bubbles c=%0d got=%h want=%h", c, obs(), expv()); end
      tick();
    end
    v = 4'b1111; for (int i = 0; i < N; i++) put(i, 3);
    settle(); tick();
    data = {4{32'hFFFF_FFF1}};
    settle();
    checks++;
    if (locked_o !== 1'b1 || obs() !== expv()) begin errors++; $display("FAIL body_lock got=%h want=%h", obs(), expv()); end
    tick();
    rst = 1'b1;
    settle(); tick();
    rst = 1'b0; v = 4'b0001; put(0, 0);
    settle();
    checks++;
    if (grant_id_o !== 2'd0 || v_o !== 1'b1 || locked_o !== 1'b0 || obs() !== expv()) begin
      errors++; $display("FAIL reset_in_body got=%h want=%h", obs(), expv());
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      v   = 4'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) put(i, ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 2));
      settle();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL random c=%0d got=%h want=%h", c, obs(), expv()); end
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_wrap3();
    logic [1:0] want [3];
    logic [2:0] vv [3];
    want[0] = 2'd2; want[1] = 2'd0; want[2] = 2'd1;
    vv[0] = 3'b100; vv[1] = 3'b101; vv[2] = 3'b111;
    rst3 = 1'b1; rdy3 = 1'b1; v3 = '0; data3 = '0;
    @(posedge clk); #1;
    rst3 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      v3 = vv[c];
      data3 = {3{28'($urandom), 4'd0}};
      #1;
      checks++;
      if (grant3_o !== want[c] || v3_o !== 1'b1 || ready3 !== (3'b001 << want[c])) begin
        errors++; $display("FAIL wrap3 c=%0d got g=%0d v=%b r=%b want g=%0d", c, grant3_o, v3_o, ready3, want[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_rr_order();
    test_packet_lock();
    test_hold();
    test_bubbles_reset();
    test_random();
    test_wrap3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
